// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and the
// data load/store path; data has priority, bounded by a fetch starvation guard.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [7:0]        d_wmask_i,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic [7:0]        m_wmask_o,
    input  logic              m_gnt_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {StIdle, StIssueIf, StWaitIf, StIssueD, StWaitD} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic [DATA_W-1:0] fetch_shifted;
    logic              unused_addr_lsb;

    // Halfword offset within the beat selects the instruction window; offset 3 zero-fills.
    assign fetch_shifted   = m_rdata_i >> {addr_q[2:1], 4'b0000};
    assign unused_addr_lsb = addr_q[0];

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (!if_req_i) streak_d = '0;
                if (d_req_i && (streak_q < SW'(STARVE_LIMIT))) begin
                    state_d = StIssueD;
                    addr_d  = d_addr_i;
                    we_d    = d_we_i;
                    wdata_d = d_wdata_i;
                    wmask_d = d_wmask_i;
                    if (if_req_i) streak_d = streak_q + SW'(1);
                end else if (if_req_i && !if_flush_i) begin
                    state_d  = StIssueIf;
                    addr_d   = if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = '0;
                    streak_d = '0;
                end
            end
            StIssueIf: begin
                if (m_gnt_i) begin
                    state_d = StWaitIf;
                    if (if_flush_i) drop_d = 1'b1;
                end else if (if_flush_i) begin
                    state_d = StIdle;
                end
            end
            StWaitIf: begin
                if (if_flush_i) drop_d = 1'b1;
                if (m_rvalid_i) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                    if (!drop_q && !if_flush_i) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = fetch_shifted[31:0];
                    end
                end
            end
            StIssueD: begin
                if (m_gnt_i) state_d = StWaitD;
            end
            StWaitD: begin
                if (m_rvalid_i) begin
                    state_d    = StIdle;
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = m_rdata_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        m_req_o   = (state_q == StIssueIf) || (state_q == StIssueD);
        m_addr_o  = m_req_o ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
        m_we_o    = (state_q == StIssueD) && we_q;
        m_wdata_o = (state_q == StIssueD) ? wdata_q : '0;
        m_wmask_o = (state_q == StIssueD) ? wmask_q : '0;
    end

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;

endmodule
